// File: rtl/cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : cpu_multicycle
// Description : Parametrised multicycle core for the 16-bit instruction set.
//               It uses one shared instruction/data memory port with a req/ack
//               handshake, so memory latency stalls the core.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_multicycle #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int INIT_REG   = 1,
  parameter int RESULT_REG = 2,
  parameter int LINK_REG   = 15
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic [DATA_W-1:0] initial_input,
  output logic [DATA_W-1:0] result_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [2:0]        state
);

  // FSM encoding
  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_halted = 3'd5;

  // Opcodes
  localparam logic [3:0] c_op_add  = 4'h0;
  localparam logic [3:0] c_op_sub  = 4'h1;
  localparam logic [3:0] c_op_and  = 4'h2;
  localparam logic [3:0] c_op_or   = 4'h3;
  localparam logic [3:0] c_op_xor  = 4'h4;
  localparam logic [3:0] c_op_slt  = 4'h5;
  localparam logic [3:0] c_op_addi = 4'h6;
  localparam logic [3:0] c_op_lw   = 4'h7;
  localparam logic [3:0] c_op_sw   = 4'h8;
  localparam logic [3:0] c_op_beq  = 4'h9;
  localparam logic [3:0] c_op_j    = 4'hA;
  localparam logic [3:0] c_op_bl   = 4'hB;
  localparam logic [3:0] c_op_br   = 4'hC;
  localparam logic [3:0] c_op_halt = 4'hD;

  localparam logic [3:0] c_result_idx = 4'(RESULT_REG);
  localparam logic [3:0] c_link_idx   = 4'(LINK_REG);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_npc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_regs [16];

  logic [3:0]        w_op;
  logic [3:0]        w_rs;
  logic [3:0]        w_rt;
  logic [3:0]        w_rd;
  logic [DATA_W-1:0] w_imm4;
  logic [ADDR_W-1:0] w_imm4_pc;
  logic [ADDR_W-1:0] w_imm8_pc;
  logic [ADDR_W-1:0] w_j_target;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_rf_we;
  logic [3:0]        w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;

  assign w_op      = r_ir[15:12];
  assign w_rs      = r_ir[11:8];
  assign w_rt      = r_ir[7:4];
  assign w_rd      = r_ir[3:0];
  assign w_imm4    = DATA_W'($signed(r_ir[3:0]));
  assign w_imm4_pc = ADDR_W'($signed(r_ir[3:0]));
  assign w_imm8_pc = ADDR_W'($signed(r_ir[11:4]));

  // Jump keeps the upper PC bits of PC+1 only when the address is wider than the 12-bit field
  generate
    if (ADDR_W > 12) begin : g_jump_wide
      assign w_j_target = {r_npc[ADDR_W-1:12], r_ir[11:0]};
    end else begin : g_jump_narrow
      assign w_j_target = r_ir[11:0];
    end
  endgenerate

  // Outputs: requests are gated by reset so they fall the moment reset is asserted
  assign mem_req    = pc_reset && ((r_state == c_st_fetch) || (r_state == c_st_mem));
  assign mem_we     = pc_reset && (r_state == c_st_mem) && (w_op == c_op_sw);
  assign mem_addr   = (r_state == c_st_mem) ? r_alu[ADDR_W-1:0] : r_pc;
  assign mem_wdata  = r_b;
  assign halted     = (r_state == c_st_halted);
  assign state      = r_state;
  assign result_reg = r_regs[c_result_idx];

  // ALU: register-register ops, everything else is base + imm4
  always_comb begin
    w_alu_out = r_a + w_imm4;
    case (w_op)
      c_op_add: w_alu_out = r_a + r_b;
      c_op_sub: w_alu_out = r_a - r_b;
      c_op_and: w_alu_out = r_a & r_b;
      c_op_or:  w_alu_out = r_a | r_b;
      c_op_xor: w_alu_out = r_a ^ r_b;
      c_op_slt: w_alu_out = DATA_W'($signed(r_a) < $signed(r_b));
      default:  w_alu_out = r_a + w_imm4;
    endcase
  end

  // Register-file write port, active only in WB
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_alu;
    if (r_state == c_st_wb) begin
      case (w_op)
        c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_slt: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_rd;
        end
        c_op_addi: w_rf_we = 1'b1;
        c_op_lw: begin
          w_rf_we    = 1'b1;
          w_rf_wdata = r_mdr;
        end
        c_op_bl: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = c_link_idx;
          w_rf_wdata = DATA_W'(r_npc);
        end
        default: w_rf_we = 1'b0;
      endcase
    end
  end

  // Register file; the init register follows initial_input while reset is held
  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= (i == INIT_REG) ? initial_input : '0;
      end
    end else if (w_rf_we) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Control FSM and datapath latches
  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      r_state <= c_st_fetch;
      r_pc    <= '0;
      r_npc   <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
    end else begin
      case (r_state)
        c_st_fetch: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata[15:0];
            r_npc   <= r_pc + 1'b1;
            r_state <= c_st_decode;
          end
        end
        c_st_decode: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_state <= c_st_exec;
        end
        c_st_exec: begin
          r_alu <= w_alu_out;
          case (w_op)
            c_op_lw, c_op_sw: r_state <= c_st_mem;
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor, c_op_slt, c_op_addi:
              r_state <= c_st_wb;
            c_op_bl: begin
              r_alu   <= DATA_W'(r_npc + w_imm8_pc);
              r_state <= c_st_wb;
            end
            c_op_beq: begin
              r_pc    <= (r_a == r_b) ? (r_npc + w_imm4_pc) : r_npc;
              r_state <= c_st_fetch;
            end
            c_op_j: begin
              r_pc    <= w_j_target;
              r_state <= c_st_fetch;
            end
            c_op_br: begin
              r_pc    <= r_a[ADDR_W-1:0];
              r_state <= c_st_fetch;
            end
            c_op_halt: r_state <= c_st_halted;
            default: begin
              r_pc    <= r_npc;
              r_state <= c_st_fetch;
            end
          endcase
        end
        c_st_mem: begin
          if (mem_ack) begin
            if (w_op == c_op_sw) begin
              r_pc    <= r_npc;
              r_state <= c_st_fetch;
            end else begin
              r_mdr   <= mem_rdata;
              r_state <= c_st_wb;
            end
          end
        end
        c_st_wb: begin
          r_pc    <= (w_op == c_op_bl) ? r_alu[ADDR_W-1:0] : r_npc;
          r_state <= c_st_fetch;
        end
        c_st_halted: r_state <= c_st_halted;
        default:     r_state <= c_st_fetch;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_multicycle
// Description : Directed bench for cpu_multicycle: a 16-bit and a 32-bit
//               instance, each with a unified memory of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_multicycle;

  logic clk;
  int   checks;
  int   errors;
  int   cyc;

  // 16-bit instance signals
  logic        rst16, req16, we16, ack16, halted16;
  logic [15:0] init16, res16, addr16, wdata16, rdata16;
  logic [2:0]  state16;
  logic [15:0] mem16 [256];
  int          lat16, cnt16, fcnt16, wcnt16;
  logic [15:0] flog16 [16];
  logic [15:0] waddr16, wdl16;

  // 32-bit instance signals
  logic        rst32, req32, we32, ack32, halted32;
  logic [31:0] init32, res32, wdata32, rdata32;
  logic [15:0] addr32;
  logic [2:0]  state32;
  logic [31:0] mem32 [256];
  int          lat32, cnt32, fcnt32;
  logic [15:0] flog32 [16];

  cpu_multicycle #(.DATA_W(16), .ADDR_W(16)) u_dut16 (
    .clk(clk), .pc_reset(rst16), .initial_input(init16), .result_reg(res16),
    .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
    .mem_rdata(rdata16), .mem_ack(ack16), .halted(halted16), .state(state16)
  );

  cpu_multicycle #(.DATA_W(32), .ADDR_W(16)) u_dut32 (
    .clk(clk), .pc_reset(rst32), .initial_input(init32), .result_reg(res32),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
    .mem_rdata(rdata32), .mem_ack(ack32), .halted(halted32), .state(state32)
  );

  always #5 clk = ~clk;

  // Memory models: ack after lat request cycles (lat = 1 is zero-wait)
  assign ack16   = req16 && (cnt16 == lat16 - 1);
  assign rdata16 = mem16[addr16[7:0]];
  assign ack32   = req32 && (cnt32 == lat32 - 1);
  assign rdata32 = mem32[addr32[7:0]];

  always @(posedge clk or negedge rst16) begin
    if (!rst16) begin
      cnt16 <= 0; fcnt16 <= 0; wcnt16 <= 0;
    end else if (req16) begin
      if (ack16) begin
        cnt16 <= 0;
        if (we16) begin
          mem16[addr16[7:0]] = wdata16;
          waddr16 <= addr16; wdl16 <= wdata16; wcnt16 <= wcnt16 + 1;
        end else if (state16 == 3'd0 && fcnt16 < 16) begin
          flog16[fcnt16] <= addr16; fcnt16 <= fcnt16 + 1;
        end
      end else cnt16 <= cnt16 + 1;
    end else cnt16 <= 0;
  end

  always @(posedge clk or negedge rst32) begin
    if (!rst32) begin
      cnt32 <= 0; fcnt32 <= 0;
    end else if (req32) begin
      if (ack32) begin
        cnt32 <= 0;
        if (we32) mem32[addr32[7:0]] = wdata32;
        else if (state32 == 3'd0 && fcnt32 < 16) begin
          flog32[fcnt32] <= addr32; fcnt32 <= fcnt32 + 1;
        end
      end else cnt32 <= cnt32 + 1;
    end else cnt32 <= 0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear16();
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
  endtask

  task automatic hold16(input logic [15:0] init, input int lat);
    rst16 = 1'b0; init16 = init; lat16 = lat;
    tick(); tick();
  endtask

  task automatic run16(input int max);
    while (!halted16 && cyc < max) begin tick(); cyc++; end
  endtask

  initial begin
    clk = 1'b0; checks = 0; errors = 0; cyc = 0;
    rst16 = 1'b0; init16 = '0; lat16 = 1;
    rst32 = 1'b0; init32 = '0; lat32 = 1;
    for (int i = 0; i < 256; i++) mem32[i] = 32'h0;

    // Test 1: ADDI R2,R1,3 ; HALT, zero-wait memory
    clear16(); mem16[0] = 16'h6123; mem16[1] = 16'hD000;
    hold16(16'h0005, 1);
    check("rst_state", 32'(state16), 32'd0);
    check("rst_req", 32'(req16), 32'd0);
    check("rst_we", 32'(we16), 32'd0);
    check("rst_halted", 32'(halted16), 32'd0);
    check("rst_result", 32'(res16), 32'h0);
    rst16 = 1'b1; cyc = 0;
    run16(50);
    check("t1_result", 32'(res16), 32'h0008);
    check("t1_halted", 32'(halted16), 32'd1);
    check("t1_cycles", 32'(cyc), 32'd7);

    // Test 2: LW R2,0(R1) with 3-cycle ack
    clear16(); mem16[0] = 16'h7120; mem16[1] = 16'hD000; mem16[5] = 16'h1234;
    hold16(16'h0005, 3);
    rst16 = 1'b1; cyc = 0;
    while (state16 != 3'd3 && cyc < 20) begin tick(); cyc++; end
    check("t2_mem_req", 32'(req16), 32'd1);
    check("t2_mem_addr", 32'(addr16), 32'h0005);
    check("t2_mem_we", 32'(we16), 32'd0);
    tick(); cyc++;
    check("t2_wait_req", 32'(req16), 32'd1);
    check("t2_wait_addr", 32'(addr16), 32'h0005);
    check("t2_wait_we", 32'(we16), 32'd0);
    run16(60);
    check("t2_result", 32'(res16), 32'h1234);
    check("t2_cycles", 32'(cyc), 32'd14);

    // Test 3: J 0x10 ; SW R1,1(R0) ; LW R2,1(R0) ; HALT
    clear16();
    mem16[0] = 16'hA010; mem16[16] = 16'h8011; mem16[17] = 16'h7021; mem16[18] = 16'hD000;
    hold16(16'h0005, 1);
    rst16 = 1'b1; cyc = 0;
    run16(60);
    check("t3_wcount", 32'(wcnt16), 32'd1);
    check("t3_waddr", 32'(waddr16), 32'h0001);
    check("t3_wdata", 32'(wdl16), 32'h0005);
    check("t3_result", 32'(res16), 32'h0005);

    // Test 4: BEQ taken once back to 3, SUB breaks the loop, falls through
    clear16();
    mem16[0] = 16'h6130; mem16[1] = 16'hA004; mem16[2] = 16'hE000;
    mem16[3] = 16'h1313; mem16[4] = 16'h931E; mem16[5] = 16'h6327; mem16[6] = 16'hD000;
    hold16(16'h0005, 2);
    rst16 = 1'b1; cyc = 0;
    run16(120);
    check("t4_result", 32'(res16), 32'h0007);
    check("t4_fcount", 32'(fcnt16), 32'd7);
    check("t4_fetch2", 32'(flog16[2]), 32'h0004);
    check("t4_fetch3", 32'(flog16[3]), 32'h0003);
    check("t4_fetch4", 32'(flog16[4]), 32'h0004);
    check("t4_fetch5", 32'(flog16[5]), 32'h0005);

    // Test 5: BL +3 at 0x10, BR R15, R2 = R15
    clear16();
    mem16[0] = 16'hA010; mem16[16] = 16'hB030; mem16[20] = 16'hCF00;
    mem16[17] = 16'h0F02; mem16[18] = 16'hD000;
    hold16(16'h0005, 1);
    rst16 = 1'b1; cyc = 0;
    run16(60);
    check("t5_result", 32'(res16), 32'h0011);
    check("t5_fetch1", 32'(flog16[1]), 32'h0010);
    check("t5_fetch2", 32'(flog16[2]), 32'h0014);
    check("t5_fetch3", 32'(flog16[3]), 32'h0011);
    check("t5_fetch4", 32'(flog16[4]), 32'h0012);

    // Test 6: 32-bit SUB R2,R0,R1 ; HALT with reset pulsed mid-fetch
    mem32[0] = 32'h0000_1012; mem32[1] = 32'h0000_D000;
    rst32 = 1'b0; init32 = 32'h1; lat32 = 3;
    tick(); tick();
    rst32 = 1'b1; cyc = 0;
    while (!(req32 && addr32 == 16'h0001) && cyc < 30) begin tick(); cyc++; end
    tick();
    check("t6_pre_req", 32'(req32), 32'd1);
    check("t6_pre_result", res32, 32'hFFFF_FFFF);
    rst32 = 1'b0; #1;
    check("t6_async_req", 32'(req32), 32'd0);
    check("t6_async_state", 32'(state32), 32'd0);
    check("t6_async_result", res32, 32'h0);
    tick();
    rst32 = 1'b1; cyc = 0;
    while (!halted32 && cyc < 60) begin tick(); cyc++; end
    check("t6_halted", 32'(halted32), 32'd1);
    check("t6_result", res32, 32'hFFFF_FFFF);
    check("t6_fetch0", 32'(flog32[0]), 32'h0);
    check("t6_fetch1", 32'(flog32[1]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
